// File: rtl/sync_memory_unit_pkg.sv
// sync_memory_unit_pkg
//   Shared types and helpers for the sync_memory_unit slice: clear-sequencer
//   state encoding, access opcode values and an even-parity helper.
//   The parity helper is used only when SYNC_MEMORY_UNIT_PARITY_EN is defined.
package sync_memory_unit_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Widest word the parity helper accepts; callers zero-extend, which does
    // not change the parity.
    localparam int PAR_MAX_W = 256;

    // Even parity bit: makes the total count of ones (data + bit) even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_memory_unit_if.sv
// sync_memory_unit_if
//   Access/debug bundle between the datapath bus (master) and the memory
//   unit (slave).
//   master drives : req, op, address, in_bus, clear [, inject_err]
//   slave drives  : ready, out_bus, out_valid, stored_value [, parity_err]
//   The bracketed signals exist only with SYNC_MEMORY_UNIT_PARITY_EN defined.
interface sync_memory_unit_if #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic                   req;
    logic                   op;
    logic [ADDR_W-1:0]      address;
    logic [WIDTH-1:0]       in_bus;
    logic                   clear;
    logic                   ready;
    logic [WIDTH-1:0]       out_bus;
    logic                   out_valid;
    logic [DEPTH*WIDTH-1:0] stored_value;
`ifdef SYNC_MEMORY_UNIT_PARITY_EN
    logic                   inject_err;
    logic                   parity_err;

    modport master (
        output req, op, address, in_bus, clear, inject_err,
        input  ready, out_bus, out_valid, stored_value, parity_err
    );
    modport slave (
        input  req, op, address, in_bus, clear, inject_err,
        output ready, out_bus, out_valid, stored_value, parity_err
    );
`else
    modport master (
        output req, op, address, in_bus, clear,
        input  ready, out_bus, out_valid, stored_value
    );
    modport slave (
        input  req, op, address, in_bus, clear,
        output ready, out_bus, out_valid, stored_value
    );
`endif
endinterface

// File: rtl/sync_memory_unit_mem_clear_fsm.sv
// mem_clear_fsm
//   Clear sequencer for sync_memory_unit: on clear in IDLE it walks an
//   address counter 0..DEPTH-1, one word per cycle, then returns to IDLE.
//   Ports:
//     clk, rst_n    clock, async active-low reset
//     clear_i       start sweep (looked at in IDLE only)
//     ready_o       1 in IDLE (port may accept req/clear)
//     sweep_we_o    1 while sweeping: write CLEAR_VAL at sweep_addr_o
//     sweep_addr_o  word being cleared this cycle
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | port open; clear_i starts a sweep at counter 0
//   CLEAR | word[counter] cleared each edge; leaves after word DEPTH-1
module mem_clear_fsm
    import sync_memory_unit_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    output logic              ready_o,
    output logic              sweep_we_o,
    output logic [ADDR_W-1:0] sweep_addr_o
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (clear_i) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                    end
                end
                CLEAR: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign sweep_we_o   = (state_q == CLEAR);
    assign sweep_addr_o = cnt_q;

endmodule

// File: rtl/sync_memory_unit.sv
// sync_memory_unit
//   DEPTH x WIDTH synchronous memory with a single shared read/write port,
//   registered read data with a one-cycle valid strobe, a built-in clear
//   sweep and a flat debug view of every stored word.
//   Ports:
//     clk, rst_n  clock, async active-low reset (all words reset to 0)
//     bus         sync_memory_unit_if.slave: req/op/address/in_bus/clear in,
//                 ready/out_bus/out_valid/stored_value out
//   Optional: SYNC_MEMORY_UNIT_PARITY_EN adds a per-word even-parity bit,
//   bus.inject_err (store parity inverted on write) and bus.parity_err
//   (flagged with out_valid on a mismatching read).
module sync_memory_unit
    import sync_memory_unit_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 8,
    parameter int               ADDR_W    = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] CLEAR_VAL = {WIDTH{1'b0}}
) (
    input logic              clk,
    input logic              rst_n,
    sync_memory_unit_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic              ready;
    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;

    mem_clear_fsm #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_clear_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (bus.clear),
        .ready_o     (ready),
        .sweep_we_o  (sweep_we),
        .sweep_addr_o(sweep_addr)
    );

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] out_bus_q;
    logic [WIDTH-1:0] out_bus_d;
    logic             out_valid_q;
    logic             in_range;
    logic             wr_acc;
    logic             rd_acc;

    // Only matters for non-power-of-two DEPTH; otherwise constant 1.
    assign in_range = ({1'b0, bus.address} < DEPTH_EXT);

    // clear wins over a same-cycle req, which is dropped.
    assign wr_acc = ready & ~bus.clear & bus.req & (bus.op == OP_WRITE) & in_range;
    assign rd_acc = ready & ~bus.clear & bus.req & (bus.op == OP_READ);

    // Out-of-range reads still complete, returning zero.
    assign out_bus_d = rd_acc ? (in_range ? mem_q[bus.address] : '0) : out_bus_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= '0;
            end
            out_bus_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_bus_q   <= out_bus_d;
            out_valid_q <= rd_acc;
            if (sweep_we) begin
                mem_q[sweep_addr] <= CLEAR_VAL;
            end else if (wr_acc) begin
                mem_q[bus.address] <= bus.in_bus;
            end
        end
    end

`ifdef SYNC_MEMORY_UNIT_PARITY_EN
    function automatic logic word_parity(input logic [WIDTH-1:0] d);
        logic [PAR_MAX_W-1:0] ext;
        ext            = '0;
        ext[WIDTH-1:0] = d;
        return even_parity(ext);
    endfunction

    logic par_q [DEPTH];
    logic parity_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Parity of an all-zero word is 0, consistent with the data reset.
            for (int j = 0; j < DEPTH; j++) begin
                par_q[j] <= 1'b0;
            end
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= rd_acc & in_range &
                            (par_q[bus.address] != word_parity(mem_q[bus.address]));
            if (sweep_we) begin
                par_q[sweep_addr] <= word_parity(CLEAR_VAL);
            end else if (wr_acc) begin
                par_q[bus.address] <= word_parity(bus.in_bus) ^ bus.inject_err;
            end
        end
    end

    assign bus.parity_err = parity_err_q;
`endif

    assign bus.ready     = ready;
    assign bus.out_bus   = out_bus_q;
    assign bus.out_valid = out_valid_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign bus.stored_value[g*WIDTH +: WIDTH] = mem_q[g];
    end

endmodule

// File: doc/sync_memory_unit.md
Name: sync_memory_unit

Overview:
- Clocked, parametrised successor to the 8x8 wordcell memory unit.
- DEPTH words of WIDTH bits; single shared read/write port with request/ready handshake; registered read data with valid strobe.
- Built-in clear sequencer: sweeps CLEAR_VAL into every word, one word per cycle, so benches and software no longer need per-address zero flashes.
- Sits between the datapath bus and the register/storage layer; exposes all stored words on a flat debug port.

Parameters:
- WIDTH, 8, word width in bits (>=1).
- DEPTH, 8, number of words (>=2; need not be a power of two).
- ADDR_W, $clog2(DEPTH), address width (derived; do not override).
- CLEAR_VAL, {WIDTH{1'b0}}, value written to every word by the clear sweep.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  access request; accepted when req & ready at a rising edge.
- op  in  1  1 = write, 0 = read (sampled with req).
- address  in  ADDR_W  word address.
- in_bus  in  WIDTH  write data.
- clear  in  1  start clear sweep (sampled in IDLE only).
- ready  out  1  1 = port accepts req/clear.
- out_bus  out  WIDTH  registered read data.
- out_valid  out  1  one-cycle strobe: out_bus holds new read data.
- stored_value  out  DEPTH*WIDTH  all words flattened; word j at [j*WIDTH +: WIDTH].

Behaviour:
- Reset (async, rst_n=0): all words = 0 (not CLEAR_VAL), out_bus = 0, out_valid = 0, state = IDLE, sweep counter = 0, ready = 1 once rst_n deasserts.
- States: IDLE, CLEAR. ready = (state == IDLE), combinational from state.
- IDLE, clear=1 at edge: enter CLEAR, counter = 0. clear takes priority; a simultaneous req is dropped, not queued.
- IDLE, req & op=1: mem[address] <= in_bus at that edge; stored_value reflects it the following cycle.
- IDLE, req & op=0: out_bus <= mem[address] at that edge; out_valid = 1 for exactly the next cycle.
  - Latency 1: a read in the cycle after a write to the same address returns the new data.
- out_bus holds its last read value when no read is accepted; out_valid = 0 except for the strobe cycle.
- CLEAR: each edge writes mem[counter] <= CLEAR_VAL, counter++. After writing word DEPTH-1, return to IDLE.
  - Sweep takes exactly DEPTH cycles, with ready = 0 throughout.
  - req and clear are ignored during CLEAR; no write, no out_valid.
- Out of range (address >= DEPTH, non-power-of-two DEPTH):
  - Write: ignored, no word changes.
  - Read: accepted, out_bus <= 0, out_valid = 1.
- Reset mid-sweep aborts immediately: state IDLE, all words 0.
- No X propagation: all storage is reset, so stored_value is never undefined after reset.

Optional Feature:
- Macro: SYNC_MEMORY_UNIT_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from in_bus on write; the clear sweep stores the parity of CLEAR_VAL.
  - Extra output parity_err (1 bit, reset 0), asserted together with out_valid when the stored parity mismatches the stored data.
  - Extra input inject_err (1 bit): when 1 on an accepted write, the parity bit is stored inverted.
- Undefined: no parity storage and no parity_err / inject_err ports; behaviour otherwise identical.

Decomposition:
- Package sync_memory_unit_pkg:
  - typedef of the state enum (IDLE, CLEAR).
  - OP_READ = 1'b0, OP_WRITE = 1'b1.
  - Function for even parity.
- One sub-module, mem_clear_fsm:
  - Holds state and sweep counter.
  - Outputs ready, sweep_we, sweep_addr.
- Storage array and read register stay in the top module.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> all stored_value words 0, ready=1, out_valid=0, out_bus=0.
- Write 8'h55 to addr 0, read addr 0 next cycle -> out_bus=8'h55 with out_valid=1 for exactly one cycle; op=1 with req=0 changes nothing.
- Write 8'hF0 to addr 4, then write 8'h0F to addr 4, then read addr 4 -> out_bus=8'h0F; stored_value word 4 = 8'h0F, all other words unchanged.
- Fill words 0..7 with 8'hA0+j, pulse clear together with a write req -> write dropped; ready=0 for exactly 8 cycles; all words = CLEAR_VAL afterwards; reqs issued mid-sweep have no effect.
- DEPTH=5, write 8'hFF to addr 6 -> no word changes; read addr 6 -> out_bus=0, out_valid=1.
- Assert rst_n=0 at sweep cycle 3 -> state IDLE, all words 0, ready=1 after release. With SYNC_MEMORY_UNIT_PARITY_EN defined: a write with inject_err=1, then a read of that address -> parity_err=1 with out_valid.
